// File: rtl/br_cond_unit_pkg.sv
// Shared architectural widths, branch kind encodings, BO bit indices and
// the branch unit FSM state type.
package br_cond_unit_pkg;

  localparam int CR_WIDTH = 32;
  localparam int CR_DEPTH = 5;

  typedef enum logic [1:0] {
    BR_KIND_B     = 2'd0,
    BR_KIND_BC    = 2'd1,
    BR_KIND_BCLR  = 2'd2,
    BR_KIND_BCCTR = 2'd3
  } br_kind_e;

  // BO field bit positions, PowerPC numbering (bit 0 is the MSB).
  localparam int BO_NOCOND  = 0;
  localparam int BO_CONDVAL = 1;
  localparam int BO_NODEC   = 2;
  localparam int BO_CTRZ    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } br_state_e;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluation: CTR decrement, BO/BI test,
// target and next-PC selection. The hint bit bo[4] never reaches here.
module br_cond_eval
  import br_cond_unit_pkg::*;
(
  input  logic [1:0]            kind,
  input  logic [0:3]            bo,
  input  logic [0:CR_DEPTH-1]   bi,
  input  logic                  aa,
  input  logic [0:31]           pc,
  input  logic [0:31]           imm,
  input  logic [0:CR_WIDTH-1]   cr_rd,
  input  logic [0:31]           ctr,
  input  logic [0:31]           lr,
  output logic                  taken,
  output logic [0:31]           target,
  output logic [0:31]           npc,
  output logic                  dec,
  output logic [0:31]           ctr_n
);

  logic        ctr_ok;
  logic        cond_ok;
  logic [0:31] seq_pc;

  // Resolve decrement, both conditions, and the destination address.
  always_comb begin
    dec     = (bo[BO_NODEC] == 1'b0) &&
              ((kind == BR_KIND_BC) || (kind == BR_KIND_BCLR));
    ctr_n   = ctr - 32'd1;
    ctr_ok  = 1'b1;
    if (dec) begin
      ctr_ok = (ctr_n != 32'd0) ^ bo[BO_CTRZ];
    end
    cond_ok = bo[BO_NOCOND] | (cr_rd[bi] == bo[BO_CONDVAL]);
    seq_pc  = pc + 32'd4;

    taken  = ctr_ok & cond_ok;
    target = aa ? imm : (pc + imm);
    case (kind)
      BR_KIND_B:     taken  = 1'b1;
      BR_KIND_BCLR:  target = lr & 32'hFFFF_FFFC;
      BR_KIND_BCCTR: target = ctr & 32'hFFFF_FFFC;
      default:       ;
    endcase

    npc = taken ? target : seq_pc;
  end

endmodule

// File: rtl/br_cond_unit.sv
// Branch resolution unit: request capture, CR-busy stall, registered
// result, and ownership of the architectural CTR and LR.
module br_cond_unit
  import br_cond_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          kind,
  input  logic [0:4]          bo,
  input  logic [0:CR_DEPTH-1] bi,
  input  logic                aa,
  input  logic                lk,
  input  logic [0:31]         pc,
  input  logic [0:31]         imm,
  input  logic [0:CR_WIDTH-1] cr_rd,
  input  logic                cr_busy,
  input  logic                ctr_wr,
  input  logic                lr_wr,
  input  logic [0:31]         spr_wd,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                taken,
  output logic [0:31]         target,
  output logic [0:31]         npc,
  output logic [0:31]         ctr_rd,
  output logic [0:31]         lr_rd
);

  br_state_e state_q, state_d;

  logic [1:0]          cap_kind;
  logic [0:3]          cap_bo;
  logic [0:CR_DEPTH-1] cap_bi;
  logic                cap_aa;
  logic                cap_lk;
  logic [0:31]         cap_pc;
  logic [0:31]         cap_imm;
  logic [0:31]         ctr_q;
  logic [0:31]         lr_q;

  logic                ev_taken;
  logic [0:31]         ev_target;
  logic [0:31]         ev_npc;
  logic                ev_dec;
  logic [0:31]         ev_ctr_n;

  logic                accept;
  logic                eval_fire;
  logic                unused_hint;

  // bo[4] is a static prediction hint with no effect on resolution.
  assign unused_hint = bo[4];

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign accept     = req_valid & req_ready;
  assign eval_fire  = (state_q == ST_EVAL) & ~cr_busy;
  assign ctr_rd     = ctr_q;
  assign lr_rd      = lr_q;

  br_cond_eval u_eval (
    .kind   (cap_kind),
    .bo     (cap_bo),
    .bi     (cap_bi),
    .aa     (cap_aa),
    .pc     (cap_pc),
    .imm    (cap_imm),
    .cr_rd  (cr_rd),
    .ctr    (ctr_q),
    .lr     (lr_q),
    .taken  (ev_taken),
    .target (ev_target),
    .npc    (ev_npc),
    .dec    (ev_dec),
    .ctr_n  (ev_ctr_n)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: stall in EVAL while the CR write is still in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)     state_d = ST_EVAL;
      ST_EVAL: if (!cr_busy)   state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Capture the decoded branch fields on request acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_kind <= '0;
      cap_bo   <= '0;
      cap_bi   <= '0;
      cap_aa   <= 1'b0;
      cap_lk   <= 1'b0;
      cap_pc   <= '0;
      cap_imm  <= '0;
    end else if (accept) begin
      cap_kind <= kind;
      cap_bo   <= bo[0:3];
      cap_bi   <= bi;
      cap_aa   <= aa;
      cap_lk   <= lk;
      cap_pc   <= pc;
      cap_imm  <= imm;
    end
  end

  // Result registers load once, on the edge leaving EVAL, and hold in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      taken  <= 1'b0;
      target <= '0;
      npc    <= '0;
    end else if (eval_fire) begin
      taken  <= ev_taken;
      target <= ev_target;
      npc    <= ev_npc;
    end
  end

  // CTR: branch decrement takes priority over a same-edge mtspr.
  always_ff @(posedge clk) begin
    if (rst)                    ctr_q <= '0;
    else if (eval_fire && ev_dec) ctr_q <= ev_ctr_n;
    else if (ctr_wr)            ctr_q <= spr_wd;
  end

  // LR: link update takes priority over a same-edge mtspr.
  always_ff @(posedge clk) begin
    if (rst)                    lr_q <= '0;
    else if (eval_fire && cap_lk) lr_q <= cap_pc + 32'd4;
    else if (lr_wr)             lr_q <= spr_wd;
  end

endmodule

// File: tb/tb_br_cond_unit.sv
// Directed-vector bench for br_cond_unit with hand-computed expectations.
module tb_br_cond_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  kind;
  logic [0:4]  bo;
  logic [0:4]  bi;
  logic        aa;
  logic        lk;
  logic [0:31] pc;
  logic [0:31] imm;
  logic [0:31] cr_rd;
  logic        cr_busy;
  logic        ctr_wr;
  logic        lr_wr;
  logic [0:31] spr_wd;
  logic        resp_valid;
  logic        resp_ready;
  logic        taken;
  logic [0:31] target;
  logic [0:31] npc;
  logic [0:31] ctr_rd;
  logic [0:31] lr_rd;

  int checks   = 0;
  int failures = 0;
  int lat;

  br_cond_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .kind       (kind),
    .bo         (bo),
    .bi         (bi),
    .aa         (aa),
    .lk         (lk),
    .pc         (pc),
    .imm        (imm),
    .cr_rd      (cr_rd),
    .cr_busy    (cr_busy),
    .ctr_wr     (ctr_wr),
    .lr_wr      (lr_wr),
    .spr_wd     (spr_wd),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .taken      (taken),
    .target     (target),
    .npc        (npc),
    .ctr_rd     (ctr_rd),
    .lr_rd      (lr_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_spr(input logic is_lr, input logic [31:0] val);
    spr_wd = val;
    if (is_lr) lr_wr = 1'b1;
    else       ctr_wr = 1'b1;
    tick();
    lr_wr  = 1'b0;
    ctr_wr = 1'b0;
  endtask

  // Issue the currently driven request; hold cr_busy for busy_n EVAL edges,
  // then present cr_after. Optionally strobe an mtspr LR during the first
  // EVAL cycle. Returns edges from accept to resp_valid (0 on timeout).
  task automatic run_branch(input int busy_n, input logic [31:0] cr_after,
                            input logic mt_lr, input logic [31:0] mt_val,
                            output int l);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    if (mt_lr) begin
      lr_wr  = 1'b1;
      spr_wd = mt_val;
    end
    l = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i <= busy_n) begin
        cr_busy = 1'b1;
      end else begin
        cr_busy = 1'b0;
        cr_rd   = cr_after;
      end
      tick();
      lr_wr = 1'b0;
      if (resp_valid) begin
        l = i;
        break;
      end
    end
    if (l == 0) check("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic set_req(input logic [1:0] k, input logic [0:4] b, input logic [0:4] i,
                         input logic a, input logic l, input logic [31:0] p,
                         input logic [31:0] m);
    kind = k; bo = b; bi = i; aa = a; lk = l; pc = p; imm = m;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    cr_busy = 1'b0; ctr_wr = 1'b0; lr_wr = 1'b0; spr_wd = '0; cr_rd = '0;
    set_req(2'd0, 5'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_req_ready",  {31'd0, req_ready},  32'd1);
    check("rst_ctr",        ctr_rd,              32'd0);
    check("rst_lr",         lr_rd,               32'd0);
    check("rst_npc",        npc,                 32'd0);
    check("rst_target",     target,              32'd0);

    // bc on CR bit 2 set, no decrement.
    set_spr(1'b0, 32'd5);
    set_req(2'd1, 5'b01100, 5'd2, 1'b0, 1'b0, 32'h100, 32'h40);
    run_branch(0, 32'h2000_0000, 1'b0, 32'd0, lat);
    check("bc_latency", lat, 32'd1);
    check("bc_taken",   {31'd0, taken}, 32'd1);
    check("bc_target",  target, 32'h140);
    check("bc_npc",     npc,    32'h140);
    check("bc_ctr",     ctr_rd, 32'd5);
    check("bc_req_ready_resp", {31'd0, req_ready}, 32'd0);
    tick();
    check("bc_hold_valid", {31'd0, resp_valid}, 32'd1);
    check("bc_hold_npc",   npc, 32'h140);
    release_resp();
    check("bc_release_valid", {31'd0, resp_valid}, 32'd0);
    check("bc_release_ready", {31'd0, req_ready},  32'd1);

    // bc with condition false: falls through.
    set_req(2'd1, 5'b00100, 5'd2, 1'b0, 1'b0, 32'h100, 32'h40);
    run_branch(0, 32'h2000_0000, 1'b0, 32'd0, lat);
    check("bcf_taken", {31'd0, taken}, 32'd0);
    check("bcf_npc",   npc, 32'h104);
    release_resp();

    // Absolute bc, always-taken form.
    set_req(2'd1, 5'b10100, 5'd0, 1'b1, 1'b0, 32'h100, 32'h800);
    run_branch(0, 32'd0, 1'b0, 32'd0, lat);
    check("bca_target", target, 32'h800);
    check("bca_npc",    npc,    32'h800);
    release_resp();

    // bdnz twice from CTR=2.
    set_spr(1'b0, 32'd2);
    set_req(2'd1, 5'b10000, 5'd0, 1'b0, 1'b0, 32'h200, 32'hFFFF_FFF0);
    run_branch(0, 32'd0, 1'b0, 32'd0, lat);
    check("bdnz1_taken",  {31'd0, taken}, 32'd1);
    check("bdnz1_target", target, 32'h1F0);
    check("bdnz1_ctr",    ctr_rd, 32'd1);
    release_resp();
    run_branch(0, 32'd0, 1'b0, 32'd0, lat);
    check("bdnz2_taken", {31'd0, taken}, 32'd0);
    check("bdnz2_npc",   npc,    32'h204);
    check("bdnz2_ctr",   ctr_rd, 32'd0);
    release_resp();

    // bdnz from CTR=0 wraps.
    run_branch(0, 32'd0, 1'b0, 32'd0, lat);
    check("bdnz_wrap_ctr",   ctr_rd, 32'hFFFF_FFFF);
    check("bdnz_wrap_taken", {31'd0, taken}, 32'd1);
    release_resp();

    // bcctr uses CTR with low bits cleared and never decrements.
    set_spr(1'b0, 32'h0000_1003);
    set_req(2'd3, 5'b10100, 5'd0, 1'b0, 1'b0, 32'h400, 32'd0);
    run_branch(0, 32'd0, 1'b0, 32'd0, lat);
    check("bcctr_taken",  {31'd0, taken}, 32'd1);
    check("bcctr_target", target, 32'h1000);
    check("bcctr_ctr",    ctr_rd, 32'h1003);
    release_resp();

    // bclrl: old LR is the target, link wins over a same-edge mtspr LR.
    set_spr(1'b1, 32'h2000);
    set_req(2'd2, 5'b10100, 5'd0, 1'b0, 1'b1, 32'h300, 32'd0);
    run_branch(0, 32'd0, 1'b1, 32'hDEAD_BEE0, lat);
    check("bclrl_taken",  {31'd0, taken}, 32'd1);
    check("bclrl_target", target, 32'h2000);
    check("bclrl_lr",     lr_rd,  32'h304);
    release_resp();

    // mtspr LR applies outside a conflicting edge.
    set_spr(1'b1, 32'h0000_5550);
    check("mtspr_lr", lr_rd, 32'h5550);

    // cr_busy for 3 cycles; only the post-busy CR value counts.
    cr_rd = 32'h0000_0000;
    set_req(2'd1, 5'b01100, 5'd1, 1'b0, 1'b0, 32'h500, 32'h20);
    run_branch(3, 32'h4000_0000, 1'b0, 32'd0, lat);
    check("busy_latency", lat, 32'd4);
    check("busy_taken",   {31'd0, taken}, 32'd1);
    check("busy_npc",     npc, 32'h520);
    release_resp();

    // Reset while holding a result in RESP.
    set_spr(1'b0, 32'd7);
    set_req(2'd1, 5'b10100, 5'd0, 1'b0, 1'b1, 32'h600, 32'h10);
    run_branch(0, 32'd0, 1'b0, 32'd0, lat);
    check("pre_rst_valid", {31'd0, resp_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready},  32'd1);
    check("mid_rst_ctr",   ctr_rd, 32'd0);
    check("mid_rst_lr",    lr_rd,  32'd0);
    check("mid_rst_npc",   npc,    32'd0);
    check("mid_rst_taken", {31'd0, taken}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
